// File: rtl/uart_port_pkg.sv
// Shared encodings and constants for the uart_port serial device (8N1, optional even parity).
// Build option: define UART_PARITY_EN to add an even parity bit on both TX and RX.
package uart_port_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // rdn/wrn are active-low strobes from the memory controller
  localparam logic STROBE_ACTIVE = 1'b0;
  localparam logic STROBE_IDLE   = 1'b1;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    T_IDLE   = 3'd0,
    T_START  = 3'd1,
    T_DATA   = 3'd2,
    T_PARITY = 3'd3,
    T_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE   = 3'd0,
    R_START  = 3'd1,
    R_DATA   = 3'd2,
    R_PARITY = 3'd3,
    R_STOP   = 3'd4
  } rx_state_t;
`else
  typedef enum logic [2:0] {
    T_IDLE  = 3'd0,
    T_START = 3'd1,
    T_DATA  = 3'd2,
    T_STOP  = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE  = 3'd0,
    R_START = 3'd1,
    R_DATA  = 3'd2,
    R_STOP  = 3'd4
  } rx_state_t;
`endif

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_port_rx.sv
// Receive half of uart_port: rxd synchroniser, RX FSM and the rx holding byte with its data_ready flag.
// Build option: UART_PARITY_EN adds an R_PARITY state; a parity mismatch drops the byte like a framing error.
module uart_port_rx
  import uart_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rd_clr,
  output logic [7:0] rx_buf,
  output logic       data_ready
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic             rx_sync1, rx_sync2, rx_prev;
  rx_state_t        rx_state, rx_state_nxt;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
  logic [2:0]       rx_bit, rx_bit_nxt;
  logic [7:0]       rx_shift, rx_shift_nxt;
  logic [7:0]       rx_buf_nxt;
  logic             ready_nxt;
  logic             frame_ok;
  logic             byte_ok;
`ifdef UART_PARITY_EN
  logic             par_ok, par_ok_nxt;
`endif

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      rx_sync1   <= 1'b1;
      rx_sync2   <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= R_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_buf     <= 8'h00;
      data_ready <= 1'b0;
`ifdef UART_PARITY_EN
      par_ok     <= 1'b1;
`endif
    end else begin
      rx_sync1   <= rxd;
      rx_sync2   <= rx_sync1;
      rx_prev    <= rx_sync2;
      rx_state   <= rx_state_nxt;
      rx_cnt     <= rx_cnt_nxt;
      rx_bit     <= rx_bit_nxt;
      rx_shift   <= rx_shift_nxt;
      rx_buf     <= rx_buf_nxt;
      data_ready <= ready_nxt;
`ifdef UART_PARITY_EN
      par_ok     <= par_ok_nxt;
`endif
    end
  end

  // Start bit is re-checked half a bit in, then every data/stop bit is sampled at its centre
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    byte_ok      = 1'b0;
    frame_ok     = 1'b0;
`ifdef UART_PARITY_EN
    par_ok_nxt   = par_ok;
`endif

    case (rx_state)
      R_IDLE: begin
        rx_cnt_nxt = '0;
        rx_bit_nxt = '0;
        if (rx_prev && !rx_sync2) rx_state_nxt = R_START;
      end
      R_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = rx_sync2 ? R_IDLE : R_DATA;
        end else begin
          rx_cnt_nxt = rx_cnt + CNT_W'(1);
        end
      end
      R_DATA: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_nxt   = '0;
          rx_shift_nxt = {rx_sync2, rx_shift[7:1]};
          if (rx_bit == LAST_BIT) begin
            rx_bit_nxt = '0;
`ifdef UART_PARITY_EN
            rx_state_nxt = R_PARITY;
`else
            rx_state_nxt = R_STOP;
`endif
          end else begin
            rx_bit_nxt = rx_bit + 3'd1;
          end
        end else begin
          rx_cnt_nxt = rx_cnt + CNT_W'(1);
        end
      end
`ifdef UART_PARITY_EN
      R_PARITY: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_nxt   = '0;
          par_ok_nxt   = (rx_sync2 == even_parity(rx_shift));
          rx_state_nxt = R_STOP;
        end else begin
          rx_cnt_nxt = rx_cnt + CNT_W'(1);
        end
      end
`endif
      R_STOP: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = R_IDLE;
`ifdef UART_PARITY_EN
          frame_ok = rx_sync2 && par_ok;
`else
          frame_ok = rx_sync2;
`endif
          byte_ok  = frame_ok;
        end else begin
          rx_cnt_nxt = rx_cnt + CNT_W'(1);
        end
      end
      default: rx_state_nxt = R_IDLE;
    endcase
  end

  // A completing byte beats a simultaneous read-clear, so overruns keep data_ready set
  always_comb begin
    rx_buf_nxt = rx_buf;
    ready_nxt  = data_ready;
    if (byte_ok) begin
      rx_buf_nxt = rx_shift;
      ready_nxt  = 1'b1;
    end else if (rd_clr) begin
      ready_nxt = 1'b0;
    end
  end

endmodule

// File: rtl/uart_port.sv
// Device end of the CPU serial-port handshake: rdn/wrn strobe logic, transmit holding register and TX FSM.
// Build option: UART_PARITY_EN inserts an even parity bit (T_PARITY) after data bit 7.
module uart_port
  import uart_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  input  logic [15:0] data_i,
  output logic [15:0] data_o,
  output logic        data_oe,
  input  logic        rdn,
  input  logic        wrn,
  output logic        data_ready,
  output logic        tbre,
  output logic        tsre,
  input  logic        rxd,
  output logic        txd
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic             rdn_q, wrn_q;
  logic             rd_edge, wr_edge;
  logic [7:0]       rx_buf;
  logic             unused_data_hi;

  tx_state_t        tx_state, tx_state_nxt;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
  logic [2:0]       tx_bit, tx_bit_nxt;
  logic [7:0]       thr, thr_nxt;
  logic [7:0]       tx_shift, tx_shift_nxt;
  logic             tbre_nxt, tsre_nxt, txd_nxt;
  logic             load, bit_end;
`ifdef UART_PARITY_EN
  logic             tx_par, tx_par_nxt;
`endif

  assign unused_data_hi = ^data_i[15:8];

  assign data_o  = {8'h00, rx_buf};
  assign data_oe = (rdn == STROBE_ACTIVE);
  assign rd_edge = (rdn_q == STROBE_ACTIVE) && (rdn == STROBE_IDLE);
  assign wr_edge = (wrn_q == STROBE_ACTIVE) && (wrn == STROBE_IDLE);

  uart_port_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .rxd       (rxd),
    .rd_clr    (rd_edge),
    .rx_buf    (rx_buf),
    .data_ready(data_ready)
  );

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      rdn_q    <= STROBE_IDLE;
      wrn_q    <= STROBE_IDLE;
      tx_state <= T_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      thr      <= 8'h00;
      tx_shift <= 8'h00;
      tbre     <= 1'b1;
      tsre     <= 1'b1;
      txd      <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      rdn_q    <= rdn;
      wrn_q    <= wrn;
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      thr      <= thr_nxt;
      tx_shift <= tx_shift_nxt;
      tbre     <= tbre_nxt;
      tsre     <= tsre_nxt;
      txd      <= txd_nxt;
`ifdef UART_PARITY_EN
      tx_par   <= tx_par_nxt;
`endif
    end
  end

  // tx_shift[0] always holds the bit currently on the line during T_DATA
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_bit_nxt   = tx_bit;
    thr_nxt      = thr;
    tx_shift_nxt = tx_shift;
    tbre_nxt     = tbre;
    tsre_nxt     = tsre;
    txd_nxt      = txd;
    load         = 1'b0;
    bit_end      = (tx_cnt == CNT_LAST);
`ifdef UART_PARITY_EN
    tx_par_nxt   = tx_par;
`endif

    if (tx_state != T_IDLE) tx_cnt_nxt = bit_end ? '0 : tx_cnt + CNT_W'(1);

    case (tx_state)
      T_IDLE: begin
        if (!tbre) load = 1'b1;
      end
      T_START: begin
        if (bit_end) begin
          tx_state_nxt = T_DATA;
          txd_nxt      = tx_shift[0];
        end
      end
      T_DATA: begin
        if (bit_end) begin
          if (tx_bit == LAST_BIT) begin
            tx_bit_nxt = '0;
`ifdef UART_PARITY_EN
            tx_state_nxt = T_PARITY;
            txd_nxt      = tx_par;
`else
            tx_state_nxt = T_STOP;
            txd_nxt      = 1'b1;
`endif
          end else begin
            tx_bit_nxt   = tx_bit + 3'd1;
            txd_nxt      = tx_shift[1];
            tx_shift_nxt = {1'b0, tx_shift[7:1]};
          end
        end
      end
`ifdef UART_PARITY_EN
      T_PARITY: begin
        if (bit_end) begin
          tx_state_nxt = T_STOP;
          txd_nxt      = 1'b1;
        end
      end
`endif
      T_STOP: begin
        if (bit_end) begin
          if (!tbre) begin
            load = 1'b1;
          end else begin
            tsre_nxt     = 1'b1;
            tx_state_nxt = T_IDLE;
          end
        end
      end
      default: begin
        tx_state_nxt = T_IDLE;
        txd_nxt      = 1'b1;
      end
    endcase

    if (load) begin
      tx_shift_nxt = thr;
      tbre_nxt     = 1'b0 | 1'b1;
      tsre_nxt     = 1'b0;
      tx_state_nxt = T_START;
      tx_cnt_nxt   = '0;
      tx_bit_nxt   = '0;
      txd_nxt      = 1'b0;
`ifdef UART_PARITY_EN
      tx_par_nxt   = even_parity(thr);
`endif
    end

    // A write coinciding with the THR->shifter move is kept in THR for the next frame
    if (wr_edge && (tbre || load)) begin
      thr_nxt  = data_i[7:0];
      tbre_nxt = 1'b0;
    end
  end

endmodule
